elastic_pipeline: RTL

//  Parametrised successor to the fixed delay line: a STAGES-deep registered pipe carrying WIDTH-bit data

---
 rtl/elastic_pipeline_pkg.sv | 9 +
 rtl/elastic_stage.sv | 50 +++++
 rtl/elastic_pipeline.sv | 98 +++++++++
 3 files changed

// File: rtl/elastic_pipeline_pkg.sv
// Shared helpers for the elastic pipeline slice.
package elastic_pipeline_pkg;

  // Width of a counter able to hold 0..stages inclusive.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One pipeline slot: a valid bit plus a data register with a load enable.
// Data only captures when the incoming beat is valid, so bubbles never toggle it.
module elastic_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic             v_d_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Next-state: load from upstream when enabled; flush clears only the valid bit.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load_i) begin
      v_d = v_i;
      if (v_i) begin
        d_d = d_i;
      end
    end
    if (flush_i) begin
      v_d = 1'b0;
    end
  end

  // Slot registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o   = v_q;
  assign v_d_o = v_d;
  assign d_o   = d_q;

endmodule

// File: rtl/elastic_pipeline.sv
// STAGES-deep registered valid/ready pipe with optional bubble collapsing,
// synchronous flush and a registered occupancy count.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STAGES          = 1,
  parameter int unsigned BUBBLE_COLLAPSE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int unsigned OW = occ_width(STAGES);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  d_q   [STAGES];
  logic [WIDTH-1:0]  src_d [STAGES];
  logic [STAGES:0]   adv;
  logic [OW-1:0]     occ_q, occ_d;

  // Advance chain: collapse mode ripples readiness back from the output slot
  // (a slot moves if it is empty or its successor moves); lockstep mode uses one enable.
  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (BUBBLE_COLLAPSE != 0) begin
        adv[STAGES-1-k] = !v_q[STAGES-1-k] || adv[STAGES-k];
      end else begin
        adv[STAGES-1-k] = out_ready || !v_q[STAGES-1];
      end
    end
  end

  // Source of each slot: the input port for slot 0, the previous slot otherwise.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = d_q[k-1];
    end
  end

  assign load = adv[STAGES-1:0];

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    elastic_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush_i(flush),
      .load_i (load[g]),
      .v_i    (src_v[g]),
      .d_i    (src_d[g]),
      .v_o    (v_q[g]),
      .v_d_o  (v_d[g]),
      .d_o    (d_q[g])
    );
  end

  // Occupancy is counted from the next valid vector so the register always matches popcount(v).
  always_comb begin
    occ_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OW'(v_d[k]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

endmodule
